// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM state codes, opcode/funct
// constants, ALU operation enum and the instruction legality/ALU-op decoders.
package mips_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   function automatic logic op_legal(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
               default:                               ok = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Non-R-type instructions that use the ALU only need an add.
   function automatic alu_op_e alu_op_of(input logic [5:0] op, input logic [5:0] funct);
      alu_op_e res;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_SUB:  res = ALU_SUB;
            FN_AND:  res = ALU_AND;
            FN_OR:   res = ALU_OR;
            FN_SLT:  res = ALU_SLT;
            default: res = ALU_ADD;
         endcase
      end else begin
         res = ALU_ADD;
      end
      return res;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, register 0 reads as zero and ignores writes.
module mips_regfile #(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        raddr_a,
   input  logic [4:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_r [0:31];

   // Register storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we && (waddr != 5'd0)) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? {DATA_W{1'b0}} : regs_r[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? {DATA_W{1'b0}} : regs_r[raddr_b];

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) on a req/ack bus.
// Optional MIPS_MULTICYCLE_PERF_EN adds 32-bit cycle and retired-instruction counters.
module mips_multicycle
   import mips_pkg::*;
#(
   parameter int              DATA_W   = 32,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
)(
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [PC_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [PC_W-1:0]   o_pc,
   output logic [2:0]        o_state,
   output logic              o_retire,
   output logic              o_halt
`ifdef MIPS_MULTICYCLE_PERF_EN
   ,
   output logic [31:0]       o_cycle_cnt,
   output logic [31:0]       o_instret_cnt
`endif
);

   logic [2:0]        state_r;
   logic [PC_W-1:0]   pc_r;
   logic [31:0]       ir_r;
   logic [DATA_W-1:0] a_r, b_r, imm_r, alu_r, mdr_r;
   alu_op_e           alu_op_r;

   logic [5:0]        op_s, funct_s;
   logic [4:0]        rs_s, rt_s, rd_s;
   logic [DATA_W-1:0] rs_val_s, rt_val_s, opb_s, alu_s, wb_data_s;
   logic [PC_W-1:0]   pc_plus4_s, br_target_s, j_target_s, mem_addr_s, ctrl_pc_s;
   logic              is_rtype_s, is_lw_s, is_sw_s, is_ctrl_s, lt_s;
   logic [4:0]        rf_waddr_s;

   assign op_s    = ir_r[31:26];
   assign rs_s    = ir_r[25:21];
   assign rt_s    = ir_r[20:16];
   assign rd_s    = ir_r[15:11];
   assign funct_s = ir_r[5:0];

   assign is_rtype_s = (op_s == OP_RTYPE);
   assign is_lw_s    = (op_s == OP_LW);
   assign is_sw_s    = (op_s == OP_SW);
   assign is_ctrl_s  = (op_s == OP_BEQ) || (op_s == OP_BNE) || (op_s == OP_J);

   assign pc_plus4_s  = pc_r + PC_W'(3'd4);
   assign br_target_s = pc_plus4_s + {{(PC_W-18){ir_r[15]}}, ir_r[15:0], 2'b00};
   assign j_target_s  = {pc_plus4_s[PC_W-1:28], ir_r[25:0], 2'b00};
   assign mem_addr_s  = PC_W'(alu_r);

   // ALU and next-PC selection for control-flow instructions.
   always_comb begin
      opb_s = is_rtype_s ? b_r : imm_r;
      lt_s  = ($signed(a_r) < $signed(opb_s));
      case (alu_op_r)
         ALU_ADD: alu_s = a_r + opb_s;
         ALU_SUB: alu_s = a_r - opb_s;
         ALU_AND: alu_s = a_r & opb_s;
         ALU_OR:  alu_s = a_r | opb_s;
         ALU_SLT: alu_s = {{(DATA_W-1){1'b0}}, lt_s};
         default: alu_s = a_r + opb_s;
      endcase
      case (op_s)
         OP_J:    ctrl_pc_s = j_target_s;
         OP_BEQ:  ctrl_pc_s = (a_r == b_r) ? br_target_s : pc_plus4_s;
         OP_BNE:  ctrl_pc_s = (a_r != b_r) ? br_target_s : pc_plus4_s;
         default: ctrl_pc_s = pc_plus4_s;
      endcase
   end

   assign rf_waddr_s = is_rtype_s ? rd_s : rt_s;
   assign wb_data_s  = is_lw_s ? mdr_r : alu_r;

   mips_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk     (i_clk),
      .rst     (i_rst),
      .we      (state_r == ST_WB),
      .waddr   (rf_waddr_s),
      .wdata   (wb_data_s),
      .raddr_a (rs_s),
      .raddr_b (rt_s),
      .rdata_a (rs_val_s),
      .rdata_b (rt_val_s)
   );

   // Main FSM and datapath registers; reset abandons any in-flight transaction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r  <= ST_FETCH;
         pc_r     <= RESET_PC;
         ir_r     <= 32'd0;
         a_r      <= {DATA_W{1'b0}};
         b_r      <= {DATA_W{1'b0}};
         imm_r    <= {DATA_W{1'b0}};
         alu_r    <= {DATA_W{1'b0}};
         mdr_r    <= {DATA_W{1'b0}};
         alu_op_r <= ALU_ADD;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (i_mem_ack) begin
                  ir_r    <= i_mem_rdata[31:0];
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               a_r      <= rs_val_s;
               b_r      <= rt_val_s;
               imm_r    <= {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
               alu_op_r <= alu_op_of(op_s, funct_s);
               state_r  <= op_legal(op_s, funct_s) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
               alu_r <= alu_s;
               if (is_ctrl_s) begin
                  pc_r    <= ctrl_pc_s;
                  state_r <= ST_FETCH;
               end else if (is_lw_s || is_sw_s) begin
                  state_r <= ST_MEM;
               end else begin
                  state_r <= ST_WB;
               end
            end
            ST_MEM: begin
               if (i_mem_ack) begin
                  if (is_sw_s) begin
                     pc_r    <= pc_plus4_s;
                     state_r <= ST_FETCH;
                  end else begin
                     mdr_r   <= i_mem_rdata;
                     state_r <= ST_WB;
                  end
               end
            end
            ST_WB: begin
               pc_r    <= pc_plus4_s;
               state_r <= ST_FETCH;
            end
            ST_HALT: state_r <= ST_HALT;
            default: state_r <= ST_HALT;
         endcase
      end
   end

   // Bus and status outputs are forced idle for as long as reset is held.
   assign o_mem_req   = !i_rst && ((state_r == ST_FETCH) || (state_r == ST_MEM));
   assign o_mem_we    = !i_rst && (state_r == ST_MEM) && is_sw_s;
   assign o_mem_addr  = (state_r == ST_MEM) ? mem_addr_s : pc_r;
   assign o_mem_wdata = b_r;
   assign o_pc        = pc_r;
   assign o_state     = state_r;
   assign o_halt      = !i_rst && (state_r == ST_HALT);
   assign o_retire    = !i_rst && ((state_r == ST_WB) ||
                                   ((state_r == ST_EXEC) && is_ctrl_s) ||
                                   ((state_r == ST_MEM) && is_sw_s && i_mem_ack));

`ifdef MIPS_MULTICYCLE_PERF_EN
   logic [31:0] cycle_cnt_r, instret_cnt_r;

   // Performance counters, frozen once the core has halted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cycle_cnt_r   <= 32'd0;
         instret_cnt_r <= 32'd0;
      end else if (state_r != ST_HALT) begin
         cycle_cnt_r   <= cycle_cnt_r + 32'd1;
         instret_cnt_r <= instret_cnt_r + {31'd0, o_retire};
      end
   end

   assign o_cycle_cnt   = cycle_cnt_r;
   assign o_instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: a bus responder with programmable ack
// latency checks every request against a scoreboard of expected transactions.
`timescale 1ns/1ps
module tb_mips_multicycle;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack = 1'b0;
   logic [31:0] rdata = 32'd0;
   logic        o_mem_req, o_mem_we, o_retire, o_halt;
   logic [31:0] o_mem_addr, o_mem_wdata, o_pc;
   logic [2:0]  o_state;
`ifdef MIPS_MULTICYCLE_PERF_EN
   logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif

   always #5 clk = ~clk;

   mips_multicycle #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h0)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ack(ack), .i_mem_rdata(rdata),
      .o_pc(o_pc), .o_state(o_state), .o_retire(o_retire), .o_halt(o_halt)
`ifdef MIPS_MULTICYCLE_PERF_EN
      , .o_cycle_cnt(o_cycle_cnt), .o_instret_cnt(o_instret_cnt)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic [31:0] exp;
   } vec_t;

   bus_t        sbq[$];
   bus_t        cap;
   logic [31:0] mem [0:255];
   int          checks = 0, errors = 0;
   int          ack_wait = 0, wcnt = 0;
   int          cycles, retires;
   int          ret_cyc [0:15];
   bit          halted;

   function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(input logic [25:0] tgt);
      return {6'h02, tgt};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus_t e;
      e.we = we; e.addr = addr; e.wdata = wdata;
      sbq.push_back(e);
   endtask

   task automatic new_prog();
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      sbq.delete();
   endtask

   // One bus cycle of the responder: stability check, then ack after ack_wait waits.
   task automatic mem_step();
      bus_t e;
      if (ack) begin
         ack = 1'b0;
         wcnt = 0;
      end
      if (o_mem_req) begin
         if (wcnt == 0) begin
            cap.we = o_mem_we; cap.addr = o_mem_addr; cap.wdata = o_mem_wdata;
         end else begin
            chk("req_stable_we", 32'(o_mem_we), 32'(cap.we));
            chk("req_stable_addr", o_mem_addr, cap.addr);
            if (cap.we) chk("req_stable_wdata", o_mem_wdata, cap.wdata);
         end
         if (wcnt >= ack_wait) begin
            ack = 1'b1;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_req: actual addr=%0h we=%0b expected no request", o_mem_addr, o_mem_we);
            end else begin
               e = sbq.pop_front();
               chk("bus_we", 32'(o_mem_we), 32'(e.we));
               chk("bus_addr", o_mem_addr, e.addr);
               if (e.we) chk("bus_wdata", o_mem_wdata, e.wdata);
            end
            if (o_mem_we) mem[o_mem_addr[9:2]] = o_mem_wdata;
            else          rdata = mem[o_mem_addr[9:2]];
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   endtask

   task automatic do_reset(input bit chk_rst);
      @(negedge clk);
      rst = 1'b1; ack = 1'b0; wcnt = 0;
      @(negedge clk);
      @(negedge clk);
      if (chk_rst) begin
         chk("rst_state", 32'(o_state), 32'd0);
         chk("rst_pc", o_pc, 32'h0);
         chk("rst_req", 32'(o_mem_req), 32'd0);
         chk("rst_we", 32'(o_mem_we), 32'd0);
         chk("rst_retire", 32'(o_retire), 32'd0);
         chk("rst_halt", 32'(o_halt), 32'd0);
      end
      rst = 1'b0;
      #1;
   endtask

   // Runs from negedge+1 of the first post-reset cycle until n_ret retires, halt or budget.
   task automatic run(input int n_ret, input int max_cyc);
      cycles = 0; retires = 0; halted = 1'b0;
      while ((retires < n_ret) && !halted && (cycles < max_cyc)) begin
         mem_step();
         #1;
         cycles++;
         if (o_retire) begin
            if (retires < 16) ret_cyc[retires] = cycles;
            retires++;
         end
         if (o_halt) halted = 1'b1;
         if ((retires < n_ret) && !halted) begin
            @(negedge clk);
            #1;
         end
      end
   endtask

   vec_t vec [0:12];
   bit   any_req;

   initial begin
      vec[0]  = '{"add_pos_neg", 6'h00, 6'h20, 32'd5,        32'hFFFFFFFD, 16'h0,    32'd2};
      vec[1]  = '{"add_wrap_ov", 6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        16'h0,    32'h80000000};
      vec[2]  = '{"add_wrap_0",  6'h00, 6'h20, 32'hFFFFFFFF, 32'd1,        16'h0,    32'h0};
      vec[3]  = '{"sub_neg",     6'h00, 6'h22, 32'd3,        32'd5,        16'h0,    32'hFFFFFFFE};
      vec[4]  = '{"sub_wrap",    6'h00, 6'h22, 32'h80000000, 32'd1,        16'h0,    32'h7FFFFFFF};
      vec[5]  = '{"and",         6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    32'h00F000F0};
      vec[6]  = '{"or",          6'h00, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    32'hFFF0FFF0};
      vec[7]  = '{"slt_m1_1",    6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd1};
      vec[8]  = '{"slt_1_m1",    6'h00, 6'h2A, 32'd1,        32'hFFFFFFFF, 16'h0,    32'd0};
      vec[9]  = '{"slt_min_max", 6'h00, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 16'h0,    32'd1};
      vec[10] = '{"slt_equal",   6'h00, 6'h2A, 32'd5,        32'd5,        16'h0,    32'd0};
      vec[11] = '{"addi_neg",    6'h08, 6'h00, 32'd10,       32'd0,        16'hFFFF, 32'd9};
      vec[12] = '{"addi_wrap",   6'h08, 6'h00, 32'h7FFFFFFF, 32'd0,        16'h0001, 32'h80000000};

      // addi/addi/add then store $3, zero-wait bus.
      new_prog();
      ack_wait = 0;
      mem[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
      mem[1] = i_ins(6'h08, 5'd2, 5'd0, 16'hFFFD);
      mem[2] = r_ins(6'h20, 5'd3, 5'd1, 5'd2);
      mem[3] = i_ins(6'h2B, 5'd3, 5'd0, 16'h0040);
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h4, 32'h0); push(1'b0, 32'h8, 32'h0);
      push(1'b0, 32'hC, 32'h0); push(1'b1, 32'h40, 32'd2);
      do_reset(1'b1);
      run(4, 100);
      chk("s1_retires", 32'(retires), 32'd4);
      chk("s1_cycles_3_instr", 32'(ret_cyc[2]), 32'd12);
      chk("s1_sw_latency", 32'(ret_cyc[3] - ret_cyc[2]), 32'd4);
      chk("s1_result_mem", mem[16], 32'd2);
      chk("s1_sb_drained", 32'(sbq.size()), 32'd0);

      // ALU table: operands loaded from memory, result stored back.
      for (int i = 0; i < 13; i++) begin
         new_prog();
         ack_wait = i % 3;
         mem[0] = i_ins(6'h23, 5'd1, 5'd0, 16'h0100);
         mem[1] = i_ins(6'h23, 5'd2, 5'd0, 16'h0104);
         mem[2] = (vec[i].op == 6'h00) ? r_ins(vec[i].fn, 5'd3, 5'd1, 5'd2)
                                       : i_ins(vec[i].op, 5'd3, 5'd1, vec[i].imm);
         mem[3] = i_ins(6'h2B, 5'd3, 5'd0, 16'h0108);
         mem[64] = vec[i].a;
         mem[65] = vec[i].b;
         mem[66] = 32'hDEADBEEF;
         push(1'b0, 32'h0, 32'h0);   push(1'b0, 32'h100, 32'h0);
         push(1'b0, 32'h4, 32'h0);   push(1'b0, 32'h104, 32'h0);
         push(1'b0, 32'h8, 32'h0);   push(1'b0, 32'hC, 32'h0);
         push(1'b1, 32'h108, vec[i].exp);
         do_reset(1'b0);
         run(4, 200);
         chk({vec[i].name, "_retires"}, 32'(retires), 32'd4);
         chk({vec[i].name, "_result"}, mem[66], vec[i].exp);
         chk({vec[i].name, "_lw_latency"}, 32'(ret_cyc[0]), 32'(5 + 2 * ack_wait));
         chk({vec[i].name, "_sb_drained"}, 32'(sbq.size()), 32'd0);
      end

      // sw then lw through 2-cycle ack; program lives at 0x40 to keep 8/12 as data.
      new_prog();
      ack_wait = 1;
      mem[0]  = j_ins(26'h10);
      mem[16] = i_ins(6'h08, 5'd3, 5'd0, 16'd2);
      mem[17] = i_ins(6'h2B, 5'd3, 5'd0, 16'h0008);
      mem[18] = i_ins(6'h23, 5'd4, 5'd0, 16'h0008);
      mem[19] = i_ins(6'h2B, 5'd4, 5'd0, 16'h000C);
      push(1'b0, 32'h0, 32'h0);  push(1'b0, 32'h40, 32'h0); push(1'b0, 32'h44, 32'h0);
      push(1'b1, 32'h8, 32'd2);  push(1'b0, 32'h48, 32'h0); push(1'b0, 32'h8, 32'h0);
      push(1'b0, 32'h4C, 32'h0); push(1'b1, 32'hC, 32'd2);
      do_reset(1'b0);
      run(5, 200);
      chk("s2_retires", 32'(retires), 32'd5);
      chk("s2_sw_latency", 32'(ret_cyc[2] - ret_cyc[1]), 32'd6);
      chk("s2_lw_latency", 32'(ret_cyc[3] - ret_cyc[2]), 32'd7);
      chk("s2_lw_data", mem[3], 32'd2);
      chk("s2_sb_drained", 32'(sbq.size()), 32'd0);

      // beq $0,$0,-1 at 0x10 loops onto itself.
      new_prog();
      ack_wait = 0;
      mem[0] = j_ins(26'h4);
      mem[4] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h10, 32'h0); push(1'b0, 32'h10, 32'h0);
      do_reset(1'b0);
      run(3, 100);
      chk("beq_retires", 32'(retires), 32'd3);
      chk("j_latency", 32'(ret_cyc[0]), 32'd3);
      chk("beq_latency", 32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
      @(posedge clk); #1;
      chk("beq_target_pc", o_pc, 32'h10);

      // bne $0,$0,4 at 0x10 falls through.
      new_prog();
      mem[0] = j_ins(26'h4);
      mem[4] = i_ins(6'h05, 5'd0, 5'd0, 16'd4);
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h10, 32'h0);
      do_reset(1'b0);
      run(2, 100);
      chk("bne_nt_retires", 32'(retires), 32'd2);
      @(posedge clk); #1;
      chk("bne_nt_pc", o_pc, 32'h14);

      // beq not taken, bne taken with a non-zero register.
      new_prog();
      mem[0] = i_ins(6'h08, 5'd1, 5'd0, 16'd1);
      mem[1] = i_ins(6'h04, 5'd0, 5'd1, 16'd5);
      mem[2] = i_ins(6'h05, 5'd0, 5'd1, 16'd2);
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h4, 32'h0); push(1'b0, 32'h8, 32'h0);
      do_reset(1'b0);
      run(3, 100);
      chk("br_mix_retires", 32'(retires), 32'd3);
      @(posedge clk); #1;
      chk("bne_taken_pc", o_pc, 32'h14);

      // Illegal opcode 0x3F at 0x20 halts permanently.
      new_prog();
      mem[0] = j_ins(26'h8);
      mem[8] = 32'hFC000000;
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h20, 32'h0);
      do_reset(1'b0);
      run(5, 50);
      chk("halt_seen", 32'(halted), 32'd1);
      chk("halt_retires", 32'(retires), 32'd1);
      chk("halt_state", 32'(o_state), 32'd5);
      ack = 1'b0;
      any_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (o_mem_req) any_req = 1'b1;
      end
      chk("halt_no_req", 32'(any_req), 32'd0);
      chk("halt_pc", o_pc, 32'h20);
      chk("halt_sticky", 32'(o_halt), 32'd1);
`ifdef MIPS_MULTICYCLE_PERF_EN
      chk("perf_cycle_frozen", o_cycle_cnt, 32'd5);
      chk("perf_instret_frozen", o_instret_cnt, 32'd1);
`endif

      // Unsupported funct 0x21 halts at PC 0.
      new_prog();
      mem[0] = r_ins(6'h21, 5'd3, 5'd1, 5'd2);
      push(1'b0, 32'h0, 32'h0);
      do_reset(1'b0);
      run(1, 50);
      chk("bad_funct_halt", 32'(halted), 32'd1);
      chk("bad_funct_pc", o_pc, 32'h0);

      // Reset during lw MEM wait, asserted together with the ack.
      new_prog();
      ack_wait = 2;
      mem[0]  = i_ins(6'h23, 5'd4, 5'd0, 16'h0100);
      mem[64] = 32'h00001234;
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h100, 32'h0);
      do_reset(1'b0);
      cycles = 0;
      while (cycles < 30) begin
         mem_step();
         cycles++;
         if ((o_state == 3'd3) && ack) break;
         @(negedge clk); #1;
      end
      chk("rstmid_reached_mem", 32'(o_state), 32'd3);
      rst = 1'b1;
      #1;
      chk("rstmid_req_low", 32'(o_mem_req), 32'd0);
      chk("rstmid_retire_low", 32'(o_retire), 32'd0);
      @(negedge clk); #1;
      chk("rstmid_state", 32'(o_state), 32'd0);
      chk("rstmid_pc", o_pc, 32'h0);
      ack = 1'b0;
      new_prog();
      mem[0]  = i_ins(6'h2B, 5'd4, 5'd0, 16'h0108);
      mem[66] = 32'hDEADBEEF;
      push(1'b0, 32'h0, 32'h0); push(1'b1, 32'h108, 32'h0);
      @(negedge clk);
      rst = 1'b0; wcnt = 0;
      #1;
      chk("rstmid_first_req", 32'(o_mem_req), 32'd1);
      chk("rstmid_first_addr", o_mem_addr, 32'h0);
      run(1, 50);
      chk("rstmid_no_write", mem[66], 32'h0);
      chk("rstmid_sb_drained", 32'(sbq.size()), 32'd0);

      // Writes to $0 are discarded.
      new_prog();
      ack_wait = 0;
      mem[0]  = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
      mem[1]  = r_ins(6'h20, 5'd0, 5'd1, 5'd1);
      mem[2]  = i_ins(6'h2B, 5'd0, 5'd0, 16'h0108);
      mem[66] = 32'hDEADBEEF;
      push(1'b0, 32'h0, 32'h0); push(1'b0, 32'h4, 32'h0); push(1'b0, 32'h8, 32'h0);
      push(1'b1, 32'h108, 32'h0);
      do_reset(1'b0);
      run(3, 100);
      chk("r0_retires", 32'(retires), 32'd3);
      chk("r0_reads_zero", mem[66], 32'h0);
      @(posedge clk); #1;
`ifdef MIPS_MULTICYCLE_PERF_EN
      chk("perf_instret", o_instret_cnt, 32'(retires));
      chk("perf_cycles", o_cycle_cnt, 32'(cycles));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
